// File: rtl/snoop_responder_if.sv
// Snoop responder bus bundle: ACE AC/CR/CD snoop channels plus the local
// cache lookup and state-update ports.
//   slave  : the snoop responder's view (accepts AC, drives CR/CD, issues
//            lookups and updates)
//   master : the interconnect / cache view
interface snoop_responder_if #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned BYTES_PER_LINE = 32,
  parameter int unsigned INDEX_WIDTH    = 7,
  parameter int unsigned TAG_WIDTH      = ADDR_WIDTH - INDEX_WIDTH - $clog2(BYTES_PER_LINE)
);
  localparam int unsigned LINE_W = BYTES_PER_LINE * 8;

  // AC: snoop request
  logic                   ac_valid;
  logic                   ac_ready;
  logic [ADDR_WIDTH-1:0]  ac_addr;
  logic [3:0]             ac_snoop;
  logic [2:0]             ac_prot;
  // CR: snoop response
  logic                   cr_valid;
  logic                   cr_ready;
  logic [4:0]             cr_resp;
  // CD: snoop data
  logic                   cd_valid;
  logic                   cd_ready;
  logic [DATA_WIDTH-1:0]  cd_data;
  logic                   cd_last;
  // Cache lookup
  logic                   lkp_valid;
  logic [INDEX_WIDTH-1:0] lkp_index;
  logic [TAG_WIDTH-1:0]   lkp_tag;
  logic                   lkp_ack;
  logic                   lkp_hit;
  logic                   lkp_dirty;
  logic                   lkp_unique;
  logic [LINE_W-1:0]      lkp_data;
  // Cache state update
  logic                   upd_valid;
  logic                   upd_op;
  logic [INDEX_WIDTH-1:0] upd_index;
  logic [TAG_WIDTH-1:0]   upd_tag;
  logic                   upd_ack;

  modport slave (
    input  ac_valid, ac_addr, ac_snoop, ac_prot,
    output ac_ready,
    output cr_valid, cr_resp,
    input  cr_ready,
    output cd_valid, cd_data, cd_last,
    input  cd_ready,
    output lkp_valid, lkp_index, lkp_tag,
    input  lkp_ack, lkp_hit, lkp_dirty, lkp_unique, lkp_data,
    output upd_valid, upd_op, upd_index, upd_tag,
    input  upd_ack
  );

  modport master (
    output ac_valid, ac_addr, ac_snoop, ac_prot,
    input  ac_ready,
    input  cr_valid, cr_resp,
    output cr_ready,
    input  cd_valid, cd_data, cd_last,
    output cd_ready,
    input  lkp_valid, lkp_index, lkp_tag,
    output lkp_ack, lkp_hit, lkp_dirty, lkp_unique, lkp_data,
    input  upd_valid, upd_op, upd_index, upd_tag,
    output upd_ack
  );
endinterface

// File: rtl/snoop_responder.sv
// Cache-side ACE snoop responder. Accepts one snoop at a time on AC, looks up
// the local cache, downgrades or invalidates the line, answers on CR and, when
// data is passed, streams the whole line on CD in ascending beat order.
// Supported snoops: ReadClean (4'b0010), ReadUnique (4'b0111); anything else
// gets an all-zero response.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   bus        : snoop_responder_if.slave (AC/CR/CD + lookup + update)
module snoop_responder #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned BYTES_PER_LINE = 32,
  parameter int unsigned INDEX_WIDTH    = 7,
  parameter int unsigned TAG_WIDTH      = ADDR_WIDTH - INDEX_WIDTH - $clog2(BYTES_PER_LINE)
) (
  input logic              clk,
  input logic              reset,
  snoop_responder_if.slave bus
);
  localparam int unsigned OFF    = $clog2(BYTES_PER_LINE);
  localparam int unsigned LINE_W = BYTES_PER_LINE * 8;
  localparam int unsigned BEATS  = LINE_W / DATA_WIDTH;
  localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [3:0] SNP_READ_CLEAN  = 4'b0010;
  localparam logic [3:0] SNP_READ_UNIQUE = 4'b0111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_UPDATE,
    S_SEND_CR,
    S_SEND_CD
  } state_e;

  state_e                 state_q;
  logic [INDEX_WIDTH-1:0] index_q;
  logic [TAG_WIDTH-1:0]   tag_q;
  logic [3:0]             snoop_q;
  logic [LINE_W-1:0]      line_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   ac_ready_q;
  logic                   lkp_valid_q;
  logic                   upd_valid_q;
  logic                   upd_op_q;
  logic                   cr_valid_q;
  logic [4:0]             cr_resp_q;
  logic                   cd_valid_q;
  logic [DATA_WIDTH-1:0]  cd_data_q;
  logic                   cd_last_q;

  logic [CNT_W-1:0]       cnt_d;
  logic [DATA_WIDTH-1:0]  line_beats [BEATS];
  logic                   snoop_ok;
  logic                   snoop_clean;

  // Protection and line-offset bits carry no meaning for a whole-line snoop.
  logic unused_ok;
  assign unused_ok = ^{bus.ac_prot, bus.ac_addr[OFF-1:0]};

  // Beat slicing of the captured line and snoop-type decode.
  always_comb begin
    cnt_d       = cnt_q + CNT_W'(1);
    snoop_clean = (snoop_q == SNP_READ_CLEAN);
    snoop_ok    = snoop_clean || (snoop_q == SNP_READ_UNIQUE);
    for (int unsigned k = 0; k < BEATS; k++) begin
      line_beats[k] = line_q[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Transaction FSM; every output is a flop updated alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      index_q     <= '0;
      tag_q       <= '0;
      snoop_q     <= '0;
      line_q      <= '0;
      cnt_q       <= '0;
      ac_ready_q  <= 1'b0;
      lkp_valid_q <= 1'b0;
      upd_valid_q <= 1'b0;
      upd_op_q    <= 1'b0;
      cr_valid_q  <= 1'b0;
      cr_resp_q   <= '0;
      cd_valid_q  <= 1'b0;
      cd_data_q   <= '0;
      cd_last_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // ac_ready rises one cycle after reset release and stays up here.
          if (bus.ac_valid && ac_ready_q) begin
            index_q     <= bus.ac_addr[OFF +: INDEX_WIDTH];
            tag_q       <= bus.ac_addr[OFF+INDEX_WIDTH +: TAG_WIDTH];
            snoop_q     <= bus.ac_snoop;
            ac_ready_q  <= 1'b0;
            lkp_valid_q <= 1'b1;
            state_q     <= S_LOOKUP;
          end else begin
            ac_ready_q  <= 1'b1;
          end
        end

        S_LOOKUP: begin
          if (bus.lkp_ack) begin
            lkp_valid_q <= 1'b0;
            line_q      <= bus.lkp_data;
            if (bus.lkp_hit && snoop_ok) begin
              // {WasUnique, IsShared, PassDirty, Error, DataTransfer}
              cr_resp_q   <= {bus.lkp_unique, snoop_clean, bus.lkp_dirty, 1'b0, 1'b1};
              upd_valid_q <= 1'b1;
              upd_op_q    <= ~snoop_clean;
              state_q     <= S_UPDATE;
            end else begin
              cr_resp_q   <= '0;
              cr_valid_q  <= 1'b1;
              state_q     <= S_SEND_CR;
            end
          end
        end

        S_UPDATE: begin
          if (bus.upd_ack) begin
            upd_valid_q <= 1'b0;
            cr_valid_q  <= 1'b1;
            state_q     <= S_SEND_CR;
          end
        end

        S_SEND_CR: begin
          if (bus.cr_ready) begin
            cr_valid_q <= 1'b0;
            if (cr_resp_q[0]) begin
              cnt_q      <= '0;
              cd_valid_q <= 1'b1;
              cd_data_q  <= line_beats[0];
              cd_last_q  <= (BEATS == 1);
              state_q    <= S_SEND_CD;
            end else begin
              ac_ready_q <= 1'b1;
              state_q    <= S_IDLE;
            end
          end
        end

        S_SEND_CD: begin
          if (bus.cd_ready) begin
            if (cd_last_q) begin
              cnt_q      <= '0;
              cd_valid_q <= 1'b0;
              cd_last_q  <= 1'b0;
              ac_ready_q <= 1'b1;
              state_q    <= S_IDLE;
            end else begin
              cnt_q     <= cnt_d;
              cd_data_q <= line_beats[cnt_d];
              cd_last_q <= (cnt_d == CNT_W'(BEATS - 1));
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.ac_ready  = ac_ready_q;
  assign bus.lkp_valid = lkp_valid_q;
  assign bus.lkp_index = index_q;
  assign bus.lkp_tag   = tag_q;
  assign bus.upd_valid = upd_valid_q;
  assign bus.upd_op    = upd_op_q;
  assign bus.upd_index = index_q;
  assign bus.upd_tag   = tag_q;
  assign bus.cr_valid  = cr_valid_q;
  assign bus.cr_resp   = cr_resp_q;
  assign bus.cd_valid  = cd_valid_q;
  assign bus.cd_data   = cd_data_q;
  assign bus.cd_last   = cd_last_q;
endmodule

// File: tb/tb_snoop_responder.sv
// Self-checking bench for snoop_responder: the bench plays interconnect and
// cache, and checks each snoop against expectations derived from the snoop
// rules (response bits, update op, address split, beat slicing, latency).
module tb_snoop_responder;
  localparam int unsigned ADDR_WIDTH     = 32;
  localparam int unsigned DATA_WIDTH     = 64;
  localparam int unsigned BYTES_PER_LINE = 32;
  localparam int unsigned INDEX_WIDTH    = 7;
  localparam int unsigned TAG_WIDTH      = ADDR_WIDTH - INDEX_WIDTH - $clog2(BYTES_PER_LINE);
  localparam int unsigned LINE_W         = BYTES_PER_LINE * 8;
  localparam int unsigned BEATS          = LINE_W / DATA_WIDTH;
  localparam int unsigned W              = 256;
  localparam int          MAX_CYC        = 300;

  localparam logic [3:0] RC = 4'b0010;
  localparam logic [3:0] RU = 4'b0111;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp;
  int   n_bad;

  always #5 clk = ~clk;

  snoop_responder_if #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .BYTES_PER_LINE(BYTES_PER_LINE),
    .INDEX_WIDTH(INDEX_WIDTH), .TAG_WIDTH(TAG_WIDTH)
  ) bus ();

  snoop_responder #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .BYTES_PER_LINE(BYTES_PER_LINE),
    .INDEX_WIDTH(INDEX_WIDTH), .TAG_WIDTH(TAG_WIDTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] all_outputs();
    return W'({bus.ac_ready, bus.cr_valid, bus.cr_resp, bus.cd_valid, bus.cd_data,
               bus.cd_last, bus.lkp_valid, bus.lkp_index, bus.lkp_tag, bus.upd_valid,
               bus.upd_op, bus.upd_index, bus.upd_tag});
  endfunction

  task automatic clear_inputs();
    bus.ac_valid   = 1'b0;
    bus.cr_ready   = 1'b0;
    bus.cd_ready   = 1'b0;
    bus.lkp_ack    = 1'b0;
    bus.upd_ack    = 1'b0;
  endtask

  // One complete snoop. Called and returns at a negedge. cd_mode: 0 always
  // ready, 1 fixed stall pattern, 2 random. fast = zero-delay responders plus
  // minimum-latency checks. rst_beat >= 0 asserts reset while that beat is shown.
  task automatic do_snoop(input logic [31:0] addr, input logic [3:0] snoop,
                          input bit hit, input bit dirty, input bit uniq,
                          input logic [LINE_W-1:0] line,
                          input int lkp_dly, input int upd_dly, input int cd_mode,
                          input bit fast, input bit hold_valid, input int rst_beat);
    bit dt, finished, aborted, rdy;
    int c, r, lkp_wait, upd_wait, cd_cyc;
    int lkp_hs, upd_hs, cr_hs, beats;
    int lkp_first, upd_first, cr_first, cd_first;
    logic [4:0] exp_resp;
    logic [INDEX_WIDTH-1:0] exp_idx;
    logic [TAG_WIDTH-1:0] exp_tag;
    logic [6:0] pat;
    logic [DATA_WIDTH-1:0] exp_beat;

    pat = 7'b1011001;  // cd_ready per stalled-beat cycle, LSB first: 1,0,0,1,1,0,1
    dt = hit && (snoop == RC || snoop == RU);
    r = 0;
    if (dt) r = 1 + (dirty ? 4 : 0) + ((snoop == RC) ? 8 : 0) + (uniq ? 16 : 0);
    exp_resp = 5'(r);
    exp_idx  = INDEX_WIDTH'((addr / BYTES_PER_LINE) % (32'd1 << INDEX_WIDTH));
    exp_tag  = TAG_WIDTH'(addr / (BYTES_PER_LINE * (32'd1 << INDEX_WIDTH)));
    finished = 0; aborted = 0; cd_cyc = 0;
    lkp_wait = 0; upd_wait = 0; lkp_hs = 0; upd_hs = 0; cr_hs = 0; beats = 0;
    lkp_first = -1; upd_first = -1; cr_first = -1; cd_first = -1;

    c = 0;
    while (bus.ac_ready !== 1'b1 && c < 20) begin
      @(negedge clk);
      c++;
    end
    check("ac_ready_idle", W'(bus.ac_ready), W'(1'b1));

    bus.ac_valid   = 1'b1;
    bus.ac_addr    = addr;
    bus.ac_snoop   = snoop;
    bus.ac_prot    = 3'($urandom);
    bus.lkp_hit    = hit;
    bus.lkp_dirty  = dirty;
    bus.lkp_unique = uniq;
    bus.lkp_data   = line;
    @(negedge clk);
    c = 1;
    if (!hold_valid) bus.ac_valid = 1'b0;

    while (!finished && !aborted && c < MAX_CYC) begin
      check("ac_ready_busy", W'(bus.ac_ready), W'(1'b0));

      bus.lkp_ack = 1'b0;
      if (bus.lkp_valid) begin
        if (lkp_first < 0) lkp_first = c;
        check("lkp_index", W'(bus.lkp_index), W'(exp_idx));
        check("lkp_tag", W'(bus.lkp_tag), W'(exp_tag));
        if (lkp_wait >= lkp_dly) begin
          bus.lkp_ack = 1'b1;
          lkp_hs++;
        end
        lkp_wait++;
      end

      bus.upd_ack = 1'b0;
      if (bus.upd_valid) begin
        if (upd_first < 0) upd_first = c;
        check("upd_op", W'(bus.upd_op), W'(snoop == RU));
        check("upd_index", W'(bus.upd_index), W'(exp_idx));
        check("upd_tag", W'(bus.upd_tag), W'(exp_tag));
        if (upd_wait >= upd_dly) begin
          bus.upd_ack = 1'b1;
          upd_hs++;
        end
        upd_wait++;
      end

      bus.cd_ready = 1'b0;
      if (bus.cd_valid) begin
        if (cd_first < 0) cd_first = c;
        check("cd_after_cr", W'(cr_hs), W'(1));
        if (rst_beat >= 0 && beats == rst_beat) begin
          reset = 1'b1;
          #1;
          check("rst_outputs_now", all_outputs(), W'(0));
          clear_inputs();
          @(negedge clk);
          check("rst_outputs_held", all_outputs(), W'(0));
          reset = 1'b0;
          @(negedge clk);
          check("rst_ac_ready_back", W'(bus.ac_ready), W'(1'b1));
          aborted = 1;
        end else if (beats >= int'(BEATS)) begin
          check("cd_extra_beat", W'(beats), W'(BEATS - 1));
          finished = 1;
        end else begin
          exp_beat = line[beats*DATA_WIDTH +: DATA_WIDTH];
          check("cd_data", W'(bus.cd_data), W'(exp_beat));
          check("cd_last", W'(bus.cd_last), W'(beats == int'(BEATS) - 1));
          if (cd_mode == 0) rdy = 1'b1;
          else if (cd_mode == 1) rdy = (cd_cyc < 7) ? pat[cd_cyc] : 1'b1;
          else rdy = ($urandom_range(0, 2) != 0);
          cd_cyc++;
          bus.cd_ready = rdy;
          if (rdy) begin
            beats++;
            if (beats == int'(BEATS)) finished = 1;
          end
        end
      end

      bus.cr_ready = 1'b0;
      if (!aborted && bus.cr_valid) begin
        if (cr_first < 0) cr_first = c;
        check("cr_resp", W'(bus.cr_resp), W'(exp_resp));
        bus.cr_ready = fast ? 1'b1 : ($urandom_range(0, 2) != 0);
        if (bus.cr_ready) begin
          cr_hs++;
          if (!dt) finished = 1;
        end
      end

      if (!aborted) begin
        @(negedge clk);
        c++;
      end
    end

    if (aborted) return;

    clear_inputs();
    check("done_in_budget", W'(finished), W'(1'b1));
    check("ac_ready_return", W'(bus.ac_ready), W'(1'b1));
    check("idle_quiet", W'({bus.cr_valid, bus.cd_valid, bus.lkp_valid, bus.upd_valid}), W'(0));
    check("lkp_handshakes", W'(lkp_hs), W'(1));
    check("upd_handshakes", W'(upd_hs), W'(dt ? 1 : 0));
    check("cr_handshakes", W'(cr_hs), W'(1));
    check("cd_handshakes", W'(beats), W'(dt ? BEATS : 0));
    if (fast) begin
      check("lat_lkp", W'(lkp_first), W'(1));
      check("lat_cr", W'(cr_first), W'(dt ? 2 + 1 : 2));
      if (dt) begin
        check("lat_upd", W'(upd_first), W'(2));
        check("lat_cd", W'(cd_first), W'(4));
      end
    end
  endtask

  logic [LINE_W-1:0] line;
  logic [3:0]        snp;
  logic [31:0]       addr;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    clear_inputs();
    bus.ac_addr    = '0;
    bus.ac_snoop   = '0;
    bus.ac_prot    = '0;
    bus.lkp_hit    = 1'b0;
    bus.lkp_dirty  = 1'b0;
    bus.lkp_unique = 1'b0;
    bus.lkp_data   = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outputs(), W'(0));
    reset = 1'b0;
    @(negedge clk);
    check("ac_ready_after_reset", W'(bus.ac_ready), W'(1'b1));

    for (int i = 0; i < int'(LINE_W / 32); i++) line[i*32 +: 32] = $urandom;
    // ReadClean miss
    do_snoop(32'h0000_1240, RC, 1'b0, 1'b0, 1'b0, line, 0, 0, 0, 1'b1, 1'b0, -1);

    for (int i = 0; i < int'(BYTES_PER_LINE); i++) line[i*8 +: 8] = 8'(i);
    // ReadClean hit clean shared
    do_snoop(32'h0004_5660, RC, 1'b1, 1'b0, 1'b0, line, 0, 0, 0, 1'b1, 1'b0, -1);
    // ReadClean hit dirty unique
    do_snoop(32'h8000_0fe0, RC, 1'b1, 1'b1, 1'b1, line, 0, 0, 0, 1'b1, 1'b0, -1);
    for (int i = 0; i < int'(LINE_W / 32); i++) line[i*32 +: 32] = $urandom;
    // ReadUnique hit dirty shared with CD stalls
    do_snoop(32'h1234_5678, RU, 1'b1, 1'b1, 1'b0, line, 0, 0, 1, 1'b1, 1'b0, -1);
    // Unsupported snoop code on a hit
    do_snoop(32'h0000_2000, 4'b0000, 1'b1, 1'b1, 1'b1, line, 0, 0, 0, 1'b1, 1'b0, -1);
    // Reset during beat 2, then a clean ReadClean
    do_snoop(32'h0000_3000, RC, 1'b1, 1'b0, 1'b0, line, 0, 0, 0, 1'b1, 1'b0, 2);
    for (int i = 0; i < int'(LINE_W / 32); i++) line[i*32 +: 32] = $urandom;
    do_snoop(32'h0000_3020, RC, 1'b1, 1'b0, 1'b1, line, 0, 0, 0, 1'b1, 1'b0, -1);

    // Randomized snoops with random responder delays and back-pressure
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < int'(LINE_W / 32); i++) line[i*32 +: 32] = $urandom;
      case ($urandom_range(0, 4))
        0, 1:    snp = RC;
        2, 3:    snp = RU;
        default: snp = 4'($urandom);
      endcase
      addr = $urandom;
      do_snoop(addr, snp, ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), line,
               $urandom_range(0, 3), $urandom_range(0, 3), 2 * int'($urandom_range(0, 1)),
               1'b0, 1'($urandom), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/snoop_responder.md
Name: snoop_responder

Overview:
- Cache-side end of the ACE snoop protocol; one instance per CPU data cache.
- Accepts one snoop request at a time on the AC channel from the coherent interconnect and looks up the local cache.
- Updates the local line state as required, returns a CRRESP on the CR channel, then streams the full line on the CD channel when data is transferred.
- Supports ReadClean (4'b0010) and ReadUnique (4'b0111).

Parameters:
ADDR_WIDTH, 32, snoop address width
DATA_WIDTH, 64, CD beat width
BYTES_PER_LINE, 32, cache line size; BEATS = BYTES_PER_LINE*8/DATA_WIDTH (default 4)
INDEX_WIDTH, 7, cache set index width
TAG_WIDTH, ADDR_WIDTH-INDEX_WIDTH-$clog2(BYTES_PER_LINE), tag width

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
ac_valid  in  1  snoop request valid
ac_ready  out  1  snoop request accepted
ac_addr  in  ADDR_WIDTH  line address; offset bits ignored
ac_snoop  in  4  snoop type
ac_prot  in  3  protection; accepted, unused
cr_valid  out  1  snoop response valid
cr_ready  in  1  snoop response accepted
cr_resp  out  5  {WasUnique, IsShared, PassDirty, Error, DataTransfer}
cd_valid  out  1  snoop data beat valid
cd_ready  in  1  snoop data beat accepted
cd_data  out  DATA_WIDTH  snoop data beat
cd_last  out  1  final beat
lkp_valid  out  1  cache lookup request
lkp_index  out  INDEX_WIDTH  lookup set index
lkp_tag  out  TAG_WIDTH  lookup tag
lkp_ack  in  1  lookup result valid (same or later cycle)
lkp_hit  in  1  line present
lkp_dirty  in  1  line dirty
lkp_unique  in  1  line held unique
lkp_data  in  BYTES_PER_LINE*8  full line contents
upd_valid  out  1  cache state update request
upd_op  out  1  0 = make clean-shared, 1 = invalidate
upd_index  out  INDEX_WIDTH  update set index
upd_tag  out  TAG_WIDTH  update tag
upd_ack  in  1  update done

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE immediately, including mid-transaction.
  - All outputs are 0 while reset is high, including ac_ready.
  - Beat counter and captured fields clear; any in-flight response is abandoned.
- Address split: off = $clog2(BYTES_PER_LINE); index = addr[off+INDEX_WIDTH-1:off]; tag = addr[ADDR_WIDTH-1:off+INDEX_WIDTH].
- IDLE:
  - ac_ready = 1.
  - On ac_valid & ac_ready, register addr and snoop, then go to LOOKUP.
- LOOKUP:
  - Hold lkp_valid = 1 with stable index/tag until lkp_ack.
  - On ack, register hit, dirty, unique and the full line.
  - Miss, or unsupported snoop code: cr_resp = 5'b00000, go to SEND_CR.
  - Otherwise go to UPDATE.
- UPDATE:
  - ReadClean: upd_op = 0. ReadUnique: upd_op = 1.
  - Hold upd_valid until upd_ack, then go to SEND_CR.
- cr_resp on a hit:
  - bit0 (DataTransfer) = 1.
  - bit2 (PassDirty) = dirty.
  - bit3 (IsShared) = 1 for ReadClean, 0 for ReadUnique.
  - bit4 (WasUnique) = unique.
  - bit1 (Error) is always 0.
- SEND_CR:
  - Hold cr_valid = 1 with stable cr_resp until cr_ready.
  - Then go to SEND_CD if DataTransfer = 1, else IDLE.
- SEND_CD:
  - Beat k carries line[k*DATA_WIDTH +: DATA_WIDTH], k = 0..BEATS-1, ascending.
  - cd_valid stays high and the beat stays stable until cd_ready; the counter advances only on handshake.
  - cd_last = 1 only on beat BEATS-1. Its handshake goes to IDLE and clears the counter.
- CD never starts before the CR handshake; only one snoop is outstanding at a time.
- Minimum latency, with lkp_ack and upd_ack high in their request cycle:
  - AC handshake in cycle 0, lkp_valid in cycle 1.
  - Hit: upd_valid cycle 2, cr_valid cycle 3, first cd_valid cycle 4.
  - Miss: cr_valid cycle 2.
- Back-to-back snoops: ac_ready returns the cycle after the last CR handshake (no data) or the last CD handshake. There are no bubbles beyond that.
- ac_valid while busy is not accepted; the request stays pending on the channel.

Test Plan:
1. ReadClean to address 0x0000_1240 on a miss (lkp_hit = 0) -> cr_resp = 5'b00000; no upd_valid, no cd_valid; ac_ready high again the cycle after the CR handshake.
2. ReadClean, hit clean, non-unique; line = 256'h...03_02_01_00 beats -> upd_op = 0; cr_resp = 5'b01001; 4 CD beats in order 0..3; cd_last on beat 3 only.
3. ReadClean, hit dirty, unique -> cr_resp = 5'b11101; upd_op = 0; 4 beats.
4. ReadUnique, hit dirty, non-unique; cd_ready toggled 1,0,0,1,1,0,1 -> upd_op = 1; cr_resp = 5'b00101; cd_data and cd_last stable during stalls; exactly 4 handshakes.
5. Snoop code 4'b0000, line hit -> cr_resp = 5'b00000; no update, no data.
6. Reset asserted during beat 2 of SEND_CD -> all outputs 0 immediately; after release, ac_ready = 1; the next ReadClean completes normally from beat 0.
